// File: rtl/lfsr_mcnto_pkg.sv
// rtl/lfsr_mcnto_pkg.sv - shared types and LFSR step helpers for lfsr_mcnto
package lfsr_mcnto_pkg;

    localparam int MAX_WIDTH = 12;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } chan_state_e;

    // Tap bit positions (tap n sits at bit n-1) for each supported width.
    function automatic logic [MAX_WIDTH-1:0] tap_mask(input int w);
        logic [MAX_WIDTH-1:0] m;
        case (w)
            3:       m = 12'h006;
            4:       m = 12'h00C;
            5:       m = 12'h014;
            6:       m = 12'h030;
            7:       m = 12'h060;
            8:       m = 12'h0B8;
            9:       m = 12'h110;
            10:      m = 12'h240;
            11:      m = 12'h500;
            12:      m = 12'h829;
            default: m = 12'h000;
        endcase
        return m;
    endfunction

    // One XNOR-feedback shift step; all-ones maps to itself (lockup).
    function automatic logic [MAX_WIDTH-1:0] lfsr_next(input logic [MAX_WIDTH-1:0] c, input int w);
        logic                 fb;
        logic [MAX_WIDTH-1:0] width_mask;
        fb         = ~^(c & tap_mask(w));
        width_mask = 12'((13'd1 << w) - 13'd1);
        return {c[MAX_WIDTH-2:0], fb} & width_mask;
    endfunction

endpackage

// File: rtl/lfsr_mcnto_chan.sv
// rtl/lfsr_mcnto_chan.sv - one LFSR terminal-count channel
module lfsr_mcnto_chan
    import lfsr_mcnto_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             cen,
    input  logic [WIDTH-1:0] count_to,
    input  logic             oneshot,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             tercnt,
    output logic             tc_flag
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    chan_state_e      state_q, state_d;
    logic             tercnt_q, tercnt_d;
    logic             flag_q, flag_d;

    // Channel state register; reset returns to a zeroed counter in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            reload_q <= '0;
            state_q  <= ST_RUN;
            tercnt_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            state_q  <= state_d;
            tercnt_q <= tercnt_d;
            flag_q   <= flag_d;
        end
    end

    // Next state: load beats count enable; a terminal set beats a flag clear.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        state_d  = state_q;
        tercnt_d = 1'b0;
        flag_d   = flag_q & ~flag_clr;
        if (load) begin
            count_d  = data;
            reload_d = data;
            state_d  = ST_RUN;
        end else if (cen && (state_q == ST_RUN)) begin
            if (count_q == count_to) begin
                tercnt_d = 1'b1;
                flag_d   = 1'b1;
                if (oneshot) begin
                    state_d = ST_HALT;
                end else begin
                    count_d = reload_q;
                end
            end else begin
                count_d = WIDTH'(lfsr_next(MAX_WIDTH'(count_q), WIDTH));
            end
        end
    end

    assign count   = count_q;
    assign tercnt  = tercnt_q;
    assign tc_flag = flag_q;

endmodule

// File: rtl/lfsr_mcnto.sv
// rtl/lfsr_mcnto.sv - multi-channel LFSR terminal counter top
module lfsr_mcnto
    import lfsr_mcnto_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] data,
    input  logic [NCH-1:0]       load,
    input  logic [NCH-1:0]       cen,
    input  logic [NCH*WIDTH-1:0] count_to,
    input  logic [NCH-1:0]       oneshot,
    input  logic [NCH-1:0]       flag_clr,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       tercnt,
    output logic [NCH-1:0]       tc_flag,
    output logic                 irq
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        lfsr_mcnto_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .data     (data[i*WIDTH +: WIDTH]),
            .load     (load[i]),
            .cen      (cen[i]),
            .count_to (count_to[i*WIDTH +: WIDTH]),
            .oneshot  (oneshot[i]),
            .flag_clr (flag_clr[i]),
            .count    (count[i*WIDTH +: WIDTH]),
            .tercnt   (tercnt[i]),
            .tc_flag  (tc_flag[i])
        );
    end

    assign irq = |tc_flag;

endmodule

// File: tb/tb_lfsr_mcnto.sv
// tb/tb_lfsr_mcnto.sv - self-checking bench for lfsr_mcnto
module tb_lfsr_mcnto;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] data;
    logic [N-1:0]   load;
    logic [N-1:0]   cen;
    logic [N*W-1:0] count_to;
    logic [N-1:0]   oneshot;
    logic [N-1:0]   flag_clr;
    logic [N*W-1:0] count;
    logic [N-1:0]   tercnt;
    logic [N-1:0]   tc_flag;
    logic           irq;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [N*W-1:0] count;
        logic [N-1:0]   ter;
        logic [N-1:0]   flag;
        logic           irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    logic [W-1:0] m_count  [N];
    logic [W-1:0] m_reload [N];
    logic         m_halt   [N];
    logic         m_ter    [N];
    logic         m_flag   [N];

    logic [W-1:0] seq [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                               4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};

    lfsr_mcnto #(.WIDTH(W), .NCH(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .load     (load),
        .cen      (cen),
        .count_to (count_to),
        .oneshot  (oneshot),
        .flag_clr (flag_clr),
        .count    (count),
        .tercnt   (tercnt),
        .tc_flag  (tc_flag),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_step(input logic [W-1:0] c);
        return {c[2:0], ~(c[3] ^ c[2])};
    endfunction

    // Advance the reference model with the inputs now driven, queue the
    // expected outputs, and clock the DUT once.
    task automatic step();
        exp_t x;
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                m_count[i] = '0; m_reload[i] = '0; m_halt[i] = 1'b0;
                m_ter[i] = 1'b0; m_flag[i] = 1'b0;
            end else begin
                m_ter[i]  = 1'b0;
                m_flag[i] = m_flag[i] & ~flag_clr[i];
                if (load[i]) begin
                    m_count[i] = data[i*W +: W]; m_reload[i] = data[i*W +: W];
                    m_halt[i] = 1'b0;
                end else if (cen[i] && !m_halt[i]) begin
                    if (m_count[i] == count_to[i*W +: W]) begin
                        m_ter[i] = 1'b1; m_flag[i] = 1'b1;
                        if (oneshot[i]) m_halt[i] = 1'b1;
                        else            m_count[i] = m_reload[i];
                    end else begin
                        m_count[i] = ref_step(m_count[i]);
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            x.count[i*W +: W] = m_count[i];
            x.ter[i]  = m_ter[i];
            x.flag[i] = m_flag[i];
        end
        x.irq = |x.flag;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; data = '0; load = '0; cen = '0;
        count_to = '0; oneshot = '0; flag_clr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        e = exp_q.pop_front();
        checks++;
        if ({count, tercnt, tc_flag, irq} !== {e.count, e.ter, e.flag, e.irq}) begin
            errors++;
            $display("FAIL reset: got %h/%b/%b/%b exp %h/%b/%b/%b", count, tercnt, tc_flag, irq, e.count, e.ter, e.flag, e.irq);
        end
        checks++;
        if ({count, tercnt, tc_flag, irq} !== '0) begin
            errors++;
            $display("FAIL reset_zero: got %h/%b/%b/%b exp all zero", count, tercnt, tc_flag, irq);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_period();
        idle_inputs();
        count_to[W-1:0] = 4'hF;
        cen[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({count, tercnt, tc_flag, irq} !== {e.count, e.ter, e.flag, e.irq}) begin
                errors++;
                $display("FAIL full_period[%0d]: got %h/%b/%b exp %h/%b/%b", k, count, tercnt, tc_flag, e.count, e.ter, e.flag);
            end
            checks++;
            if (count[W-1:0] !== seq[k % 15] || tercnt[0] !== 1'b0) begin
                errors++;
                $display("FAIL full_period_seq[%0d]: got %h ter=%b exp %h ter=0", k, count[W-1:0], tercnt[0], seq[k % 15]);
            end
        end
    endtask

    task automatic test_auto_reload();
        idle_inputs();
        data[W-1:0] = 4'h0; load[0] = 1'b1; cen[0] = 1'b1;
        count_to[W-1:0] = 4'h7;
        step();
        load[0] = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (count[W-1:0] !== 4'h0 || tercnt[0] !== 1'b0) begin
            errors++;
            $display("FAIL auto_load: got %h ter=%b exp 0 ter=0", count[W-1:0], tercnt[0]);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({count, tercnt, tc_flag, irq} !== {e.count, e.ter, e.flag, e.irq}) begin
                errors++;
                $display("FAIL auto_reload[%0d]: got %h/%b/%b/%b exp %h/%b/%b/%b", k, count, tercnt, tc_flag, irq, e.count, e.ter, e.flag, e.irq);
            end
        end
        // Fourth enabled step from 0 is the terminal compare at 7.
        checks++;
        if (tc_flag[0] !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL auto_flag: got flag=%b irq=%b exp 1/1", tc_flag[0], irq);
        end
    endtask

    task automatic test_oneshot();
        idle_inputs();
        flag_clr[0] = 1'b1;
        step();
        void'(exp_q.pop_front());
        flag_clr[0] = 1'b0;
        data[W-1:0] = 4'h0; load[0] = 1'b1; cen[0] = 1'b1;
        count_to[W-1:0] = 4'h7; oneshot[0] = 1'b1;
        step();
        void'(exp_q.pop_front());
        load[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({count, tercnt, tc_flag, irq} !== {e.count, e.ter, e.flag, e.irq}) begin
                errors++;
                $display("FAIL oneshot[%0d]: got %h/%b/%b/%b exp %h/%b/%b/%b", k, count, tercnt, tc_flag, irq, e.count, e.ter, e.flag, e.irq);
            end
        end
        checks++;
        if (count[W-1:0] !== 4'h7 || tercnt[0] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_halt: got %h ter=%b exp 7 ter=0", count[W-1:0], tercnt[0]);
        end
        data[W-1:0] = 4'h3; load[0] = 1'b1;
        step();
        load[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++;
            if ({count, tercnt, tc_flag, irq} !== {e.count, e.ter, e.flag, e.irq}) begin
                errors++;
                $display("FAIL oneshot_reload[%0d]: got %h/%b/%b exp %h/%b/%b", k, count, tercnt, tc_flag, e.count, e.ter, e.flag);
            end
            step();
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_flag_clr();
        idle_inputs();
        flag_clr[0] = 1'b1;
        step();
        e = exp_q.pop_front();
        checks++;
        if (tc_flag !== e.flag || irq !== e.irq || irq !== 1'b0) begin
            errors++;
            $display("FAIL flag_clr: got flag=%b irq=%b exp %b/0", tc_flag, irq, e.flag);
        end
        flag_clr[0] = 1'b0;
        data[W-1:0] = 4'h5; load[0] = 1'b1;
        step();
        void'(exp_q.pop_front());
        load[0] = 1'b0;
        count_to[W-1:0] = 4'h5; cen[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            flag_clr[0] = (k > 0);
            step();
            e = exp_q.pop_front();
            checks++;
            if ({count, tercnt, tc_flag, irq} !== {e.count, e.ter, e.flag, e.irq} || tercnt[0] !== 1'b1 || tc_flag[0] !== 1'b1) begin
                errors++;
                $display("FAIL flag_set_wins[%0d]: got %h/%b/%b/%b exp %h/%b/%b/%b", k, count, tercnt, tc_flag, irq, e.count, e.ter, e.flag, e.irq);
            end
        end
    endtask

    task automatic test_channel_isolation();
        idle_inputs();
        reset = 1'b1;
        step();
        void'(exp_q.pop_front());
        reset = 1'b0;
        data[2*W +: W] = 4'h3; load[2] = 1'b1;
        count_to[2*W +: W] = 4'hE;
        step();
        void'(exp_q.pop_front());
        load[2] = 1'b0; cen[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if ({count, tercnt, tc_flag, irq} !== {e.count, e.ter, e.flag, e.irq}) begin
                errors++;
                $display("FAIL chan2[%0d]: got %h/%b/%b/%b exp %h/%b/%b/%b", k, count, tercnt, tc_flag, irq, e.count, e.ter, e.flag, e.irq);
            end
            checks++;
            if (tercnt !== ((k == 2) ? 4'b0100 : 4'b0000)) begin
                errors++;
                $display("FAIL chan2_pulse[%0d]: got %b", k, tercnt);
            end
        end
    endtask

    task automatic test_lockup();
        idle_inputs();
        data[W +: W] = 4'hF; load[1] = 1'b1;
        step();
        void'(exp_q.pop_front());
        load[1] = 1'b0; cen[1] = 1'b1; count_to[W +: W] = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) count_to[W +: W] = 4'hF;
            step();
            e = exp_q.pop_front();
            checks++;
            if ({count, tercnt, tc_flag, irq} !== {e.count, e.ter, e.flag, e.irq} || count[W +: W] !== 4'hF || tercnt[1] !== (k >= 2)) begin
                errors++;
                $display("FAIL lockup[%0d]: got %h/%b/%b exp %h/%b/%b", k, count, tercnt, tc_flag, e.count, e.ter, e.flag);
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        cen = '1; count_to = {N{4'h0}};
        step();
        void'(exp_q.pop_front());
        reset = 1'b1; load = '1; data = 16'hA5C3;
        step();
        e = exp_q.pop_front();
        checks++;
        if ({count, tercnt, tc_flag, irq} !== {e.count, e.ter, e.flag, e.irq} || {count, tercnt, tc_flag, irq} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %h/%b/%b/%b exp %h/%b/%b/%b", count, tercnt, tc_flag, irq, e.count, e.ter, e.flag, e.irq);
        end
        reset = 1'b0; load = '0; cen = 4'b0001; count_to = '1;
        step();
        e = exp_q.pop_front();
        checks++;
        if (count[W-1:0] !== 4'h1 || count !== e.count) begin
            errors++;
            $display("FAIL reset_run: got %h exp %h", count, e.count);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_full_period();
        test_auto_reload();
        test_oneshot();
        test_flag_clr();
        test_channel_isolation();
        test_lockup();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_mcnto.md
# lfsr_mcnto

Multi-channel LFSR terminal counter: NCH independent maximal-length LFSR counters sharing one clock, each with a runtime-programmable terminal value, auto-reload or one-shot mode, a terminal pulse and a sticky terminal flag. It generalises the single-channel static count-to LFSR counter used in the timer and sequencing paths. It sits behind the timer register block, which drives load, count_to, mode and flag-clear per channel.

## Interface
- WIDTH, 8: counter width per channel; legal 3..12.
- NCH, 4: channel count; legal 1..16.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- data  in  NCH*WIDTH  load value, channel i at [i*WIDTH +: WIDTH].
- load  in  NCH  per-channel load strobe.
- cen  in  NCH  per-channel count enable.
- count_to  in  NCH*WIDTH  terminal value, compared every cycle.
- oneshot  in  NCH  1: halt at terminal; 0: auto-reload.
- flag_clr  in  NCH  clears tc_flag[i].
- count  out  NCH*WIDTH  current LFSR state.
- tercnt  out  NCH  registered one-cycle terminal pulse.
- tc_flag  out  NCH  sticky terminal flag.
- irq  out  1  OR of tc_flag.

## Operation
- LFSR step: next = {c[WIDTH-2:0], fb}, fb = XNOR-reduction of tap bits (tap n = c[n-1]). All-zero is valid; all-ones is the lockup state (next(all-ones) = all-ones).
- Taps: 3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4; 9:9,5; 10:10,7; 11:11,9; 12:12,6,4,1.
- Per-channel state: count, reload register, mode state RUN/HALT, tercnt, tc_flag.
- Per-channel priority each cycle: reset > load > cen.
- reset: count=0, reload=0, state=RUN, tercnt=0, tc_flag=0; irq=0.
- load: count<=data, reload<=data, state<=RUN, tercnt<=0. cen ignored that cycle.
- cen & RUN & count==count_to (terminal): tercnt<=1; tc_flag<=1; oneshot=0: count<=reload, stay RUN; oneshot=1: count held, state<=HALT.
- cen & RUN & count!=count_to: count<=next(count), tercnt<=0.
- cen=0 or HALT: count held, tercnt<=0. HALT is left only by load or reset.
- oneshot and count_to are sampled every cycle; changes take effect at the next compare.
- count_to not on the sequence from reload: channel runs the full 2^WIDTH-1 period, never terminal.
- data = all-ones: channel locks up; terminal only if count_to is also all-ones.
- tc_flag: set on terminal, cleared by flag_clr; set wins over simultaneous clear.
- Channels are fully independent; no cross-channel interaction except irq.

## Timing
- All outputs registered except irq, which is combinational OR of registered tc_flag.
- Load visible on count the cycle after the load edge.
- tercnt high for exactly the cycle after the terminal edge, coincident with count showing reload (auto) or held value (one-shot).
- Back-to-back terminals (count_to == reload, auto mode, cen=1) give tercnt high continuously.
- Reset mid-count takes effect on the next edge, all channels.

## Structure
- Package lfsr_mcnto_pkg: tap-mask function of WIDTH, lfsr_next function, RUN/HALT state enum.
- Sub-module lfsr_mcnto_chan: one channel (count, reload, state, tercnt, tc_flag); top instantiates NCH via generate and forms irq.

## Test plan
- WIDTH=4, reset then cen=1, count_to=4'hF: count 0,1,3,7,E,D,B,6,… full 15-state period, tercnt never set.
- Load 0, count_to=7, oneshot=0, cen=1: count 0,1,3,7,0,1,…; tercnt=1 on each cycle count returns to 0; tc_flag=1, irq=1.
- Same with oneshot=1: count stops at 7, tercnt single pulse, cen ignored; load 3 restarts at 3 in RUN.
- flag_clr asserted alone clears tc_flag/irq; flag_clr coincident with terminal leaves tc_flag=1.
- NCH=4, channel 2 loaded with 3, count_to=E, others idle: only tercnt[2] pulses after 2 enabled steps; channels 0,1,3 stay 0.
- Reset asserted mid-count and coincident with load: next cycle all count=0, tercnt=0, tc_flag=0, state RUN.
